// File: rtl/core_run_ctrl.sv
// Run sequencer for the 9-bit-ISA core: selects one of NPROG programs, loads its start PC,
// enables the core until HALT (plus drain), then reports done, cycle count and error status.
module core_run_ctrl #(
    parameter int                  D          = 12,
    parameter int                  NPROG      = 3,
    parameter int                  PSW        = 2,
    parameter logic [NPROG*D-1:0]  START_ADDR = {12'd200, 12'd80, 12'd0},
    parameter int                  CW         = 16,
    parameter int                  TIMEOUT    = 4095,
    parameter int                  DRAIN_CYC  = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic [PSW-1:0] prog_sel,
    input  logic          halt,
    output logic          core_en,
    output logic          core_clr,
    output logic          pc_load,
    output logic [D-1:0]  pc_load_val,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [CW-1:0] cycle_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        FIN
    } state_t;

    localparam logic [PSW:0]  NPROG_C    = (PSW+1)'(NPROG);
    localparam logic [CW-1:0] TIMEOUT_C  = CW'(TIMEOUT);
    localparam logic [1:0]    DRAIN_LAST = 2'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);

    state_t         state;
    logic [PSW-1:0] idx;
    logic [1:0]     drain_cnt;
    logic [CW-1:0]  cnt_inc;
    logic           sel_ok;

    assign sel_ok  = ({1'b0, prog_sel} < NPROG_C);
    // Saturating increment; only reachable when TIMEOUT exceeds the counter range.
    assign cnt_inc = (cycle_cnt == '1) ? cycle_cnt : cycle_cnt + 1'b1;

    always_comb begin
        pc_load_val = '0;
        if (state == LOAD)
            pc_load_val = START_ADDR[32'(idx) * D +: D];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            idx       <= '0;
            drain_cnt <= '0;
            core_en   <= 1'b0;
            core_clr  <= 1'b0;
            pc_load   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            core_clr <= 1'b0;
            pc_load  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        cycle_cnt <= '0;
                        if (sel_ok) begin
                            state    <= LOAD;
                            idx      <= prog_sel;
                            err      <= 1'b0;
                            core_clr <= 1'b1;
                            pc_load  <= 1'b1;
                            busy     <= 1'b1;
                        end else begin
                            state <= FIN;
                            err   <= 1'b1;
                            done  <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    state   <= RUN;
                    core_en <= 1'b1;
                end
                RUN: begin
                    cycle_cnt <= cnt_inc;
                    // halt has priority over a timeout landing in the same cycle
                    if (halt) begin
                        if (DRAIN_CYC == 0) begin
                            state   <= FIN;
                            core_en <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end
                    end else if (cnt_inc >= TIMEOUT_C) begin
                        state   <= FIN;
                        core_en <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b1;
                    end
                end
                DRAIN: begin
                    cycle_cnt <= cnt_inc;
                    if (drain_cnt == DRAIN_LAST) begin
                        state   <= FIN;
                        core_en <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                FIN: begin
                    if (!req) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    core_en <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
